// File: rtl/speed_frame_checker_if.sv
// speed_frame_checker_if: byte-wide receive stream into the speed frame checker.
//   tdata  - received byte
//   tvalid - byte valid
//   tlast  - last byte of frame
//   tuser  - MAC-reported error, meaningful on the tlast beat
//   tready - sink ready (the checker holds this at 1)
// Modports: master drives the stream, slave (the checker) consumes it.
interface speed_frame_checker_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/speed_frame_checker.sv
// speed_frame_checker: per-port receive checker for the speed tester.
// Validates test frames (ethertype, length, sequence, payload pattern) and
// accumulates saturating result counters while the controller has it active.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start, stop          - test-active / drain-phase levels from the controller
//   cfg_frame_len        - expected frame length in bytes, excluding FCS
//   s_axis (slave)       - received byte stream; tready is constant 1
//   ready                - registered, checker idle and able to accept start
//   results_good/bad     - good / bad test frame counts
//   results_bytes        - byte total of good frames
//   results_seq_err      - sequence discontinuities
//
// state | meaning
// IDLE  | counters hold, ready=1; start clears counters and enters RUN
// RUN   | counting frames
// DRAIN | generator halted, still counting until stop drops
module speed_frame_checker #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           cfg_frame_len,
  speed_frame_checker_if.slave  s_axis,
  output logic                  ready,
  output logic [31:0]           results_good,
  output logic [31:0]           results_bad,
  output logic [47:0]           results_bytes,
  output logic [31:0]           results_seq_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, next_state;

  logic        in_frame;
  logic        track;
  logic [15:0] byte_cnt;
  logic        eth_hi_ok;
  logic        eth_ok;
  logic [31:0] seq_sr;
  logic [7:0]  pat;
  logic        pay_err;
  logic [31:0] exp_seq;
  logic        seq_valid;

  logic        active;
  logic        clear;
  logic        beat;
  logic        track_now;
  logic        eth_ok_now;
  logic [31:0] seq_now;
  logic        pay_err_now;
  logic [16:0] frame_len;
  logic        update;
  logic        verdict_bad;
  logic        seq_have;
  logic [48:0] bytes_sum;

  assign s_axis.tready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
    end else begin
      state <= next_state;
      ready <= (next_state == IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (!start) next_state = stop ? DRAIN : IDLE;
      DRAIN: begin
        if (start)      next_state = RUN;
        else if (!stop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign active = (state != IDLE);
  assign clear  = (state == IDLE) && start;
  assign beat   = s_axis.tvalid;

  // A frame is tracked only if its first beat lands while active; the decision
  // sticks for the whole frame so a mid-frame state change cannot adopt it.
  assign track_now = in_frame ? track : active;

  // Header fields are combined with the current byte so a tlast on the byte
  // that completes a field still sees the full value.
  assign eth_ok_now  = (byte_cnt == 16'd13) ? (eth_hi_ok && (s_axis.tdata == ETHERTYPE[7:0]))
                                           : eth_ok;
  assign seq_now     = (byte_cnt == 16'd17) ? {seq_sr[23:0], s_axis.tdata} : seq_sr;
  assign pay_err_now = pay_err || ((byte_cnt >= 16'd18) && (s_axis.tdata != pat));
  assign frame_len   = {1'b0, byte_cnt} + 17'd1;
  assign seq_have    = (byte_cnt >= 16'd17);

  assign verdict_bad = (frame_len != {1'b0, cfg_frame_len}) || s_axis.tuser ||
                       pay_err_now || (byte_cnt < 16'd17);
  assign update      = beat && s_axis.tlast && track_now && active && eth_ok_now;
  assign bytes_sum   = {1'b0, results_bytes} + {32'd0, frame_len[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  <= 1'b0;
      track     <= 1'b0;
      byte_cnt  <= 16'd0;
      eth_hi_ok <= 1'b0;
      eth_ok    <= 1'b0;
      seq_sr    <= 32'd0;
      pat       <= 8'd0;
      pay_err   <= 1'b0;
    end else if (beat) begin
      if (s_axis.tlast) begin
        in_frame  <= 1'b0;
        byte_cnt  <= 16'd0;
        eth_hi_ok <= 1'b0;
        eth_ok    <= 1'b0;
        pay_err   <= 1'b0;
      end else begin
        in_frame <= 1'b1;
        if (!in_frame) track <= active;
        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        if (byte_cnt == 16'd12) eth_hi_ok <= (s_axis.tdata == ETHERTYPE[15:8]);
        if (byte_cnt == 16'd13) eth_ok <= eth_ok_now;
        if ((byte_cnt >= 16'd14) && (byte_cnt <= 16'd17)) seq_sr <= {seq_sr[23:0], s_axis.tdata};
        // pat holds the expected value of the next payload byte.
        if (byte_cnt == 16'd17) pat <= s_axis.tdata;
        else if (byte_cnt >= 16'd18) pat <= pat + 8'd1;
        pay_err <= pay_err_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      results_good    <= 32'd0;
      results_bad     <= 32'd0;
      results_bytes   <= 48'd0;
      results_seq_err <= 32'd0;
      exp_seq         <= 32'd0;
      seq_valid       <= 1'b0;
    end else if (clear) begin
      results_good    <= 32'd0;
      results_bad     <= 32'd0;
      results_bytes   <= 48'd0;
      results_seq_err <= 32'd0;
      exp_seq         <= 32'd0;
      seq_valid       <= 1'b0;
    end else if (update) begin
      if (verdict_bad) begin
        if (results_bad != '1) results_bad <= results_bad + 32'd1;
      end else begin
        if (results_good != '1) results_good <= results_good + 32'd1;
        results_bytes <= bytes_sum[48] ? '1 : bytes_sum[47:0];
      end
      if (seq_have) begin
        if (seq_valid && (seq_now != exp_seq) && (results_seq_err != '1))
          results_seq_err <= results_seq_err + 32'd1;
        exp_seq   <= seq_now + 32'd1;
        seq_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_speed_frame_checker.sv
module tb_speed_frame_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_frame_len = 16'd64;
  logic        ready;
  logic [31:0] results_good, results_bad, results_seq_err;
  logic [47:0] results_bytes;

  speed_frame_checker_if s_axis();

  speed_frame_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .s_axis(s_axis), .ready(ready),
    .results_good(results_good), .results_bad(results_bad),
    .results_bytes(results_bytes), .results_seq_err(results_seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: counts derived from whole frames, not from beats.
  longint unsigned m_good, m_bad, m_bytes, m_seq_err;
  logic [31:0]     m_exp;
  bit              m_seq_valid;
  byte unsigned    frm[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_good = 0; m_bad = 0; m_bytes = 0; m_seq_err = 0;
    m_exp = 32'd0; m_seq_valid = 1'b0;
  endtask

  task automatic model_frame(input bit err);
    int n;
    bit bad;
    logic [31:0] s;
    n = frm.size();
    if (n < 14) return;
    if ({frm[12], frm[13]} != 16'h88B5) return;
    bad = (n != int'(cfg_frame_len)) || err || (n < 18);
    s = 32'd0;
    if (n >= 18) begin
      s = {frm[14], frm[15], frm[16], frm[17]};
      for (int k = 18; k < n; k++)
        if (frm[k] != 8'((frm[17] + k - 18) % 256)) bad = 1'b1;
    end
    if (bad) m_bad++;
    else begin
      m_good++;
      m_bytes += longint'(n);
    end
    if (n >= 18) begin
      if (m_seq_valid && (s != m_exp)) m_seq_err++;
      m_exp = s + 32'd1;
      m_seq_valid = 1'b1;
    end
  endtask

  task automatic build_frame(input logic [31:0] s, input int len, input logic [15:0] et);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 12)       frm.push_back(8'($urandom));
      else if (i == 12) frm.push_back(et[15:8]);
      else if (i == 13) frm.push_back(et[7:0]);
      else if (i < 18)  frm.push_back(8'(s >> (8 * (17 - i))));
      else              frm.push_back(8'((int'(s[7:0]) + i - 18) % 256));
    end
  endtask

  // Send beats lo..hi of frm; tlast on the frame's final byte, random gaps.
  task automatic send_range(input int lo, input int hi, input bit err);
    for (int i = lo; i <= hi; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = frm[i];
      s_axis.tlast  = (i == frm.size() - 1);
      s_axis.tuser  = err && (i == frm.size() - 1);
      tick(1);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tuser  = 1'b0;
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
  endtask

  task automatic send_frame(input bit err);
    send_range(0, frm.size() - 1, err);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_good"},    {32'd0, results_good},    m_good);
    chk({tag, "_bad"},     {32'd0, results_bad},     m_bad);
    chk({tag, "_bytes"},   {16'd0, results_bytes},   m_bytes);
    chk({tag, "_seq_err"}, {32'd0, results_seq_err}, m_seq_err);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    logic [15:0] et;
    logic [31:0] s, nseq;
    bit          err;
    int          seqs[5] = '{0, 1, 2, 5, 6};

    s_axis.tvalid = 1'b0; s_axis.tdata = 8'd0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    model_clear();
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_tready", {63'd0, s_axis.tready}, 64'd1);
    check_all("rst");

    start = 1'b1;
    tick(1);
    model_clear();
    chk("run_ready", {63'd0, ready}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      build_frame(32'(i), 64, 16'h88B5);
      send_frame(1'b0);
      model_frame(1'b0);
    end
    tick(2);
    check_all("ten");
    chk("ten_good_const", {32'd0, results_good}, 64'd10);
    chk("ten_bytes_const", {16'd0, results_bytes}, 64'd640);
    chk("ten_ready", {63'd0, ready}, 64'd0);

    start = 1'b0;
    tick(2);
    chk("idle_ready", {63'd0, ready}, 64'd1);
    start = 1'b1;
    tick(1);
    model_clear();
    foreach (seqs[i]) begin
      build_frame(32'(seqs[i]), 64, 16'h88B5);
      send_frame(1'b0);
      model_frame(1'b0);
    end
    tick(1);
    check_all("gap");
    chk("gap_seq_err_const", {32'd0, results_seq_err}, 64'd1);
    build_frame(32'd3, 64, 16'h88B5);
    send_frame(1'b0);
    model_frame(1'b0);
    tick(1);
    check_all("back");
    chk("back_seq_err_const", {32'd0, results_seq_err}, 64'd2);

    build_frame(32'd4, 64, 16'h88B5);
    frm[40] = frm[40] ^ 8'h10;
    send_frame(1'b0); model_frame(1'b0);
    build_frame(32'd5, 63, 16'h88B5);
    send_frame(1'b0); model_frame(1'b0);
    build_frame(32'd6, 64, 16'h88B5);
    send_frame(1'b1); model_frame(1'b1);
    tick(1);
    check_all("bad");
    chk("bad_const", {32'd0, results_bad}, 64'd3);

    build_frame(32'd7, 64, 16'h0800);
    send_frame(1'b0); model_frame(1'b0);
    tick(1);
    check_all("ipv4");

    cfg_frame_len = 16'($urandom_range(64, 120));
    nseq = m_exp;
    for (int r = 0; r < 30; r++) begin
      len  = ($urandom_range(0, 9) < 7) ? int'(cfg_frame_len) : int'($urandom_range(10, 130));
      et   = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h88B5;
      s    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : nseq;
      nseq = s + 32'd1;
      err  = ($urandom_range(0, 9) == 0);
      build_frame(s, len, et);
      if (len > 20 && $urandom_range(0, 9) == 0)
        frm[$urandom_range(18, len - 1)] ^= 8'h01;
      send_frame(err);
      model_frame(err);
      tick(1);
      check_all("rand");
    end

    cfg_frame_len = 16'd64;
    start = 1'b0;
    tick(2);
    build_frame(32'd20, 64, 16'h88B5);
    send_range(0, 29, 1'b0);
    start = 1'b1;
    send_range(30, 63, 1'b0);
    model_clear();
    build_frame(32'd77, 64, 16'h88B5);
    send_frame(1'b0); model_frame(1'b0);
    tick(1);
    check_all("midstart");
    chk("midstart_good_const", {32'd0, results_good}, 64'd1);
    chk("midstart_seq_err_const", {32'd0, results_seq_err}, 64'd0);

    start = 1'b0;
    stop  = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      build_frame(32'(78 + i), 64, 16'h88B5);
      send_frame(1'b0); model_frame(1'b0);
      tick(250);
    end
    stop = 1'b0;
    tick(2);
    chk("drain_ready", {63'd0, ready}, 64'd1);
    check_all("drain");
    chk("drain_good_const", {32'd0, results_good}, 64'd4);
    build_frame(32'd81, 64, 16'h88B5);
    send_frame(1'b0);
    tick(5);
    check_all("hold");

    start = 1'b1;
    tick(1);
    model_clear();
    check_all("restart");
    chk("restart_ready", {63'd0, ready}, 64'd0);

    build_frame(32'd90, 64, 16'h88B5);
    send_range(0, 20, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    send_range(21, 63, 1'b0);
    model_clear();
    build_frame(32'd200, 64, 16'h88B5);
    send_frame(1'b0); model_frame(1'b0);
    tick(1);
    check_all("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/speed_frame_checker.md
# speed_frame_checker

Per-port receive checker for the speed tester. It sits downstream of the DUT port and upstream of the speed test controller. It consumes the received byte stream, validates each test frame's header, length, sequence number and payload pattern, and accumulates per-port counters. The controller gates it with `start`/`stop` and samples the counters through `results_*` and `ready`.

## Interface
- `ETHERTYPE`, 16'h88B5: ethertype that identifies test frames.
- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  test-active level from the controller.
- `stop`  in  1  drain-phase level from the controller (generator halted, receiver still counting).
- `cfg_frame_len`  in  16  expected frame length in bytes, excluding FCS; legal range 64..1514.
- `s_axis_tdata`  in  8  received byte.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tlast`  in  1  last byte of frame.
- `s_axis_tuser`  in  1  MAC-reported error, sampled on the `tlast` beat.
- `s_axis_tready`  out  1  constant 1; the checker never backpressures.
- `ready`  out  1  checker idle and able to accept `start`.
- `results_good`  out  32  frames that passed every check.
- `results_bad`  out  32  test frames that failed any check.
- `results_bytes`  out  48  bytes of good frames.
- `results_seq_err`  out  32  sequence discontinuities.

## Operation
- Frame format, 0-based byte index:
  - 0–11: MACs, ignored.
  - 12–13: ethertype, big-endian, must equal `ETHERTYPE`.
  - 14–17: sequence number `seq`, big-endian.
  - 18 onward: payload; byte k equals `(seq[7:0] + k - 18) mod 256`.
- FSM states:
  - IDLE: `ready`=1, counters hold. A cycle with `start`=1 moves to RUN; on that same edge all four counters and `exp_seq` clear to 0 and `seq_valid` clears.
  - RUN: counting. When `start`=0 and `stop`=1, go to DRAIN. When both are 0, go to IDLE.
  - DRAIN: counting continues. When `stop`=0, go to IDLE. If `start`=1 again, go to RUN without clearing.
- Frame alignment:
  - An `in_frame` flag tracks frame boundaries at all times, including in IDLE.
  - A frame whose first beat arrives outside RUN/DRAIN is ignored entirely, even if the state changes mid-frame.
  - On entering RUN mid-frame, the checker discards bytes until the next `tlast`, then starts counting.
- Byte counter: 16-bit, increments per beat, saturates at 65535, resets after `tlast`.
- Non-test frames (ethertype mismatch) are dropped silently and no counter changes.
- Test frame at `tlast`:
  - Bad if any of: length ≠ `cfg_frame_len`, `tuser`=1, any payload mismatch, or `tlast` before byte 18.
  - Good frames: `results_good`+=1 and `results_bytes`+=length.
  - Bad frames: `results_bad`+=1.
- Sequence check:
  - Applies to good and bad frames alike, but only if byte 17 was received.
  - If `seq_valid` and `seq`≠`exp_seq`, `results_seq_err`+=1.
  - Then `exp_seq`←`seq`+1 (mod 2^32) and `seq_valid`←1.
  - The first frame after a clear never counts as a sequence error.
- All counters saturate at their all-ones value; they never wrap.

## Timing
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - FSM in IDLE, `ready`=1, `in_frame`=0, all `results_*`=0, `s_axis_tready`=1.
- Input beats are sampled only when `tvalid`=1; gaps between beats are legal.
- The frame verdict is computed on the `tlast` beat; counters update on the next rising edge, so results are visible 1 cycle after `tlast`.
- `ready` is registered: it drops the cycle after `start` is sampled and rises the cycle after the return to IDLE.
- Counter clear on `start` takes priority over a simultaneous `tlast` update. A frame ending on the clear edge is not counted.
- `start` and `stop` both 1: treated as RUN.
- `rst_n` asserted mid-frame: all state is lost. After release, the partial frame tail is discarded because `in_frame`=0 and alignment waits for the next `tlast`.
- No combinational path from inputs to outputs other than the constant `s_axis_tready`.

## Test plan
- Reset, then `start`=1. Send 10 good 64-byte frames, seq 0..9 → `results_good`=10, `bytes`=640, `bad`=0, `seq_err`=0; `ready`=0.
- Seq 0,1,2,5,6 → `seq_err`=1, `good`=5. Then seq 3 → `seq_err`=2.
- Corrupt one payload byte, then send a 63-byte frame, then a frame with `tuser`=1 → `bad`=3, `good` unchanged.
- Frame with ethertype 0x0800 → all counters unchanged.
- A frame starts in IDLE and `start` rises mid-frame → frame ignored. The next good frame is counted with `good`=1 and `seq_err`=0.
- `start`→0, `stop`=1 for 1000 cycles with 3 frames, then `stop`=0 → `good`+=3, `ready`=1 one cycle after the return to IDLE, counters hold. A new `start` → counters read 0 one cycle later.
